// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared types and constants for the modulo-8 up/down counter
//
// Purpose : state enumeration and width/limit constants used by the counter
//           top level and its next-state function.
// Contents: CNT_W       - counter width in bits
//           CNT_MAX     - highest count value (wrap point)
//           cnt_state_t - 8-state enum, S0..S7 encoded as their count value

package updown_counter_pkg;

    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] CNT_MAX = 3'd7;

    // Each state's encoding is its count value so q is the state register itself.
    typedef enum logic [CNT_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } cnt_state_t;

endpackage

// File: rtl/updown_counter_3bit_ns.sv
// rtl/updown_counter_3bit_ns.sv - combinational next-state function of the up/down counter
//
// Purpose : maps (current state, direction) to the next state, wrapping
//           modulo 8 in both directions.
// Ports   : state      in  current counter state
//           updown     in  1 = step up, 0 = step down
//           next_state out state to load on the next rising clock

module updown_counter_3bit_ns
    import updown_counter_pkg::*;
(
    input  cnt_state_t state,
    input  logic       updown,
    output cnt_state_t next_state
);

    // Transitions are spelled out state by state rather than with +1/-1
    // so the machine reads as an explicit FSM table.
    always_comb begin
        next_state = S0;
        case (state)
            S0:      next_state = updown ? S1 : S7;
            S1:      next_state = updown ? S2 : S0;
            S2:      next_state = updown ? S3 : S1;
            S3:      next_state = updown ? S4 : S2;
            S4:      next_state = updown ? S5 : S3;
            S5:      next_state = updown ? S6 : S4;
            S6:      next_state = updown ? S7 : S5;
            S7:      next_state = updown ? S0 : S6;
            default: next_state = S0;
        endcase
    end

endmodule

// File: rtl/updown_counter_3bit.sv
// rtl/updown_counter_3bit.sv - 3-bit up/down counter as an 8-state Moore machine
//
// Purpose : steps one state per rising clock, up or down as selected by
//           updown, wrapping modulo 8; the state is presented directly on q.
// Ports   : clk    in  rising-edge clock
//           rst_n  in  asynchronous reset, active HIGH despite the name;
//                      while 1 the counter is forced to 0
//           updown in  direction select, 1 = up, 0 = down
//           q      out current count (registered)

module updown_counter_3bit
    import updown_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             updown,
    output logic [CNT_W-1:0] q
);

    cnt_state_t state;
    cnt_state_t next_state;

    updown_counter_3bit_ns u_ns (
        .state      (state),
        .updown     (updown),
        .next_state (next_state)
    );

    // rst_n is active high: the reset branch fires on its rising edge and
    // holds S0 for as long as it stays 1.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    assign q = state;

endmodule

// File: tb/tb_updown_counter_3bit.sv
// tb/tb_updown_counter_3bit.sv - scoreboard bench for updown_counter_3bit

module tb_updown_counter_3bit;

    logic       clk;
    logic       rst_n;
    logic       updown;
    logic [2:0] q;

    int errors = 0;
    int checks = 0;
    int mdl    = 0;
    logic [2:0] exp_q[$];

    updown_counter_3bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .updown (updown),
        .q      (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the count is an integer moved by +1 or -1 modulo 8, zero under reset.
    task automatic step(input logic dir, input logic rst_val);
        @(negedge clk);
        updown = dir;
        rst_n  = rst_val;
        if (rst_val)
            mdl = 0;
        else
            mdl = (mdl + (dir ? 1 : -1) + 8) % 8;
        exp_q.push_back(3'(mdl));
    endtask

    task automatic check_now(input string name, input logic [2:0] want);
        checks++;
        if (q !== want) begin
            errors++;
            $display("FAIL %s: q=%0d expected %0d", name, q, want);
        end
    endtask

    // Monitor: one expected value is consumed per rising edge, sampled after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                checks++;
                if (q !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: q=%0d expected %0d", $time, q, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b1;
        updown = 1'b1;
        #1;
        check_now("reset_state", 3'd0);

        // Reset held for two edges with updown=1, then release.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);            // q=1

        // Up count through the wrap.
        repeat (9) step(1'b1, 1'b0); // ends at 2

        // Down count through the wrap.
        repeat (10) step(1'b0, 1'b0); // ends at 0

        // Go to 5, then toggle direction each edge.
        repeat (3) step(1'b0, 1'b0);  // 7,6,5
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);             // 5

        // Walk down to 4 then assert reset between edges.
        step(1'b0, 1'b0);             // 4
        @(negedge clk);
        check_now("pre_async_reset", 3'd4);
        #1 rst_n = 1'b1;
        #1 check_now("async_reset_immediate", 3'd0);
        mdl = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);             // resumes at 1
        step(1'b1, 1'b0);

        // Down from reset: 7,6,5.
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Randomized run with occasional synchronous-looking reset pulses.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end
        step(1'b1, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
